// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op encodings, FSM states, op legality.
package alu_pkg;

    // {ainvert, bnegate, sel[1:0]}
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the operand-read stage, the ALU and write-back.
interface multicycle_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, cout, overflow, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, result_hi, zero, cout, overflow, err
    );

endinterface

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional operand inversion, full adder and a 4-way result select.
module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       less,
    input  logic       ainvert,
    input  logic       bnegate,
    input  logic [1:0] sel,
    output logic       result,
    output logic       cout,
    output logic       set
);
    logic aa;
    logic bb;
    logic sum;

    assign aa   = a ^ ainvert;
    assign bb   = b ^ bnegate;
    assign sum  = aa ^ bb ^ cin;
    assign cout = (aa & bb) | (cin & (aa ^ bb));
    assign set  = sum;

    always_comb begin
        result = 1'b0;
        case (sel)
            2'b00:   result = aa & bb;
            2'b01:   result = aa | bb;
            2'b10:   result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// N-bit ALU: ripple chain of bit slices for single-cycle ops plus a shift-add multiplier,
// with a valid/ready handshake on both sides and registered, held results.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    multicycle_alu_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             cout_q;
    logic             ovf_q;
    logic             err_q;

    // Ripple chain; slice 0 carry-in is bnegate so SUB/SLT get a + ~b + 1.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] slice_res;
    logic [WIDTH-1:0] slice_set;
    logic             alu_ovf;
    logic             slt_set;

    assign carry[0] = bus.op[2];

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        alu_bit_slice u_slice (
            .a       (bus.a[i]),
            .b       (bus.b[i]),
            .cin     (carry[i]),
            .less    ((i == 0) ? slt_set : 1'b0),
            .ainvert (bus.op[3]),
            .bnegate (bus.op[2]),
            .sel     (bus.op[1:0]),
            .result  (slice_res[i]),
            .cout    (carry[i+1]),
            .set     (slice_set[i])
        );
    end

    assign alu_ovf = carry[WIDTH] ^ carry[WIDTH-1];
    // Sign of the difference corrected by overflow gives a true signed compare.
    assign slt_set = slice_set[WIDTH-1] ^ alu_ovf;

    logic unused_set;
    assign unused_set = ^slice_set[WIDTH-2:0];

    // One shift-add step; {acc, mplier} doubles as the product register.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;

    assign mul_sum     = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_next    = mul_sum[WIDTH:1];
    assign mplier_next = {mul_sum[0], mplier_q[WIDTH-1:1]};

    logic             in_ready;
    logic             accept;
    logic             legal;
    logic             arith;
    logic [WIDTH-1:0] single_res;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StMul:   in_ready = 1'b0;
            StDone:  in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept     = bus.in_valid && in_ready;
    assign legal      = is_legal_op(bus.op);
    assign arith      = (bus.op == OP_ADD) || (bus.op == OP_SUB);
    assign single_res = legal ? slice_res : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (bus.op == OP_MUL) begin
                            mcand_q  <= bus.a;
                            mplier_q <= bus.b;
                            acc_q    <= '0;
                            count_q  <= '0;
                            state_q  <= StMul;
                        end else begin
                            result_q    <= single_res;
                            result_hi_q <= '0;
                            zero_q      <= (single_res == '0);
                            cout_q      <= arith ? carry[WIDTH] : 1'b0;
                            ovf_q       <= arith ? alu_ovf : 1'b0;
                            err_q       <= !legal;
                            state_q     <= StDone;
                        end
                    end else if (state_q == StDone && bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                StMul: begin
                    acc_q    <= acc_next;
                    mplier_q <= mplier_next;
                    count_q  <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        result_q    <= mplier_next;
                        result_hi_q <= acc_next;
                        zero_q      <= ({acc_next, mplier_next} == '0);
                        cout_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                        err_q       <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.zero      = zero_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu at WIDTH=8 against an arithmetic reference model.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;

    multicycle_alu_if #(.WIDTH(W)) bus ();

    multicycle_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         v;
        logic         e;
    } exp_t;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t           x;
        logic [W:0]     wide;
        logic [2*W-1:0] prod;
        x = '0;
        case (op)
            OP_AND: x.res = a & b;
            OP_OR:  x.res = a | b;
            OP_NOR: x.res = ~(a | b);
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                x.res = wide[W-1:0];
                x.c   = wide[W];
                x.v   = (a[W-1] == b[W-1]) && (x.res[W-1] != a[W-1]);
            end
            OP_SUB: begin
                x.res = a - b;
                x.c   = (a >= b);
                x.v   = (a[W-1] != b[W-1]) && (x.res[W-1] != a[W-1]);
            end
            OP_SLT: x.res = ($signed(a) < $signed(b)) ? W'(1) : '0;
            OP_MUL: begin
                prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                x.res = prod[W-1:0];
                x.hi  = prod[2*W-1:W];
            end
            default: x.e = 1'b1;
        endcase
        x.z = (x.res == '0) && (x.hi == '0);
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input exp_t x);
        chk({tag, "_result"},    32'(bus.result),    32'(x.res));
        chk({tag, "_result_hi"}, 32'(bus.result_hi), 32'(x.hi));
        chk({tag, "_zero"},      32'(bus.zero),      32'(x.z));
        chk({tag, "_cout"},      32'(bus.cout),      32'(x.c));
        chk({tag, "_overflow"},  32'(bus.overflow),  32'(x.v));
        chk({tag, "_err"},       32'(bus.err),       32'(x.e));
    endtask

    // Issue one op, measure accept-to-out_valid latency, check outputs, then consume.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        int   lat;
        logic busy_ready;
        exp_t x;
        x = model(op, a, b);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 20 && !bus.in_ready; k++) @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble operands after accept; they must not affect the result.
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.op       = 4'($urandom);
        lat          = 1;
        busy_ready   = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            busy_ready |= bus.in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), (op == OP_MUL) ? 32'(W + 1) : 32'd1);
        if (op == OP_MUL) chk({tag, "_busy_in_ready"}, 32'(busy_ready), 32'd0);
        chk_outs(tag, x);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_released"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ops [8];
        exp_t       zero_exp;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL, 4'b1111};
        zero_exp = '0;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk_outs("reset", zero_exp);
        @(negedge clk);
        reset = 1'b0;

        run_op(OP_ADD, 8'h7F, 8'h01, "add_ovf");
        run_op(OP_SUB, 8'h05, 8'h05, "sub_eq");
        run_op(OP_SLT, 8'h80, 8'h01, "slt_neg");
        run_op(OP_SLT, 8'h7F, 8'h80, "slt_pos");
        run_op(OP_MUL, 8'hFF, 8'hFF, "mul_ff");
        run_op(4'b0011, 8'hA5, 8'h5A, "illegal");

        // Back-to-back single-cycle ops with the consumer always ready.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.a         = 8'hF0;
        bus.b         = 8'h3C;
        bus.op        = OP_AND;
        @(posedge clk);
        #1;
        chk("b2b_and_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_and", 32'(bus.result), 32'h30);
        @(negedge clk);
        bus.op = OP_OR;
        @(posedge clk);
        #1;
        chk("b2b_or", 32'(bus.result), 32'hFC);
        @(negedge clk);
        bus.op = OP_NOR;
        @(posedge clk);
        #1;
        chk("b2b_nor", 32'(bus.result), 32'h03);

        // Consumer stalls; a new request must be ignored and outputs held.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = 8'h01;
        bus.b         = 8'h01;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("hold_result",    32'(bus.result),    32'h03);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_in_ready",  32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b0;

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = OP_MUL;
        bus.a        = 8'hC3;
        bus.b        = 8'h7B;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mul_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mul_in_ready",  32'(bus.in_ready),  32'd1);
        chk_outs("rst_mul", zero_exp);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mul_discarded", 32'(bus.out_valid), 32'd0);

        for (int t = 0; t < 40; t++) begin
            run_op(ops[$urandom_range(0, 7)], W'($urandom), W'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
